correlator_core: RTL
====================

CORRELATOR_CORE -- requirements
Module: correlator_core

Interface
REQ-001 SHALL have parameter NUM_INPUTS, default 8, number of pulse inputs (>=2).
REQ-002 SHALL have parameter MAX_LAG, default 25, lags -MAX_LAG..+MAX_LAG; LAGS = 2*MAX_LAG+1.
REQ-003 SHALL have parameter RESOLUTION, default 16, bit width of every counter and output word (>=4).
REQ-004 SHALL have parameter INTEGRATION_CYCLES, default 12000000, clk cycles per integration window (>=2).
REQ-005 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port reset_n  input  1  reset; asynchronous assertion; active-low.
REQ-007 SHALL have port pulse_in  input  NUM_INPUTS  asynchronous detector pulses.
REQ-008 SHALL have port enable  input  1  high = integrate; low = freeze timer and counters.
REQ-009 SHALL have port out_data  output  RESOLUTION  readout word.
REQ-010 SHALL have port out_valid  output  1  out_data valid.
REQ-011 SHALL have port out_ready  input  1  sink accepts word.
REQ-012 SHALL have port out_last  output  1  high on final word of frame.

Function
REQ-013 SHALL pass each pulse_in bit through a 2-flop synchronizer; sync_x = second-flop output.
REQ-014 SHALL keep per-input delay chains of MAX_LAG+... registers: d_x[n] = sync_x delayed n cycles, n = 0..2*MAX_LAG.
REQ-015 SHALL count, per input x, rising edges of sync_x (pulse count).
REQ-016 SHALL provide P = NUM_INPUTS*(NUM_INPUTS-1)/2 pairs (a<b), pair index p = a*(2*NUM_INPUTS-a-1)/2 + b-a-1.
REQ-017 SHALL, per pair and lag index l in 0..2*MAX_LAG, count cycles where d_a[MAX_LAG] & d_b[l] = 1; unit lag step; pulse on b k cycles after a increments index MAX_LAG-k.
REQ-018 SHALL saturate every counter at 2^RESOLUTION-1 (no wrap).
REQ-019 SHALL, with enable high, advance a window timer 0..INTEGRATION_CYCLES-1; window end = timer at INTEGRATION_CYCLES-1.
REQ-020 SHALL, with enable low, hold timer and all counters; no increments; readout unaffected.
REQ-021 SHALL, at window end, clear all counters; events in the window-end cycle count into the new window (counter loads 0 or 1).
REQ-022 SHALL implement FSM IDLE/SEND; IDLE->SEND at window end (counters copied into snapshot buffer); SEND->IDLE on accepted out_last word.
REQ-023 SHALL, at window end while in SEND, discard the new window, keep the in-flight snapshot, and set overrun_pending.
REQ-024 SHALL keep frame sequence counter, RESOLUTION-1 bits, incremented at every window end (sent or dropped), wrapping mod 2^(RESOLUTION-1).
REQ-025 SHALL emit frame of 1+NUM_INPUTS+P*LAGS words: header, pulse counts input 0 first, then correlation counts pair-major, lag-minor (l=0 first).
REQ-026 SHALL form header as {overrun_pending, sequence of snapshotted window}; overrun_pending clears when the header is accepted.
REQ-027 SHALL assert out_valid the cycle after the window-end cycle; word accepted when out_valid & out_ready.
REQ-028 SHALL hold out_data, out_valid, out_last stable while out_valid & ~out_ready.
REQ-029 SHALL allow back-to-back word transfer (one word per cycle with out_ready held high).

Reset
REQ-030 SHALL, while reset_n low, force out_valid=0, out_last=0, out_data=0, FSM=IDLE, timer, counters, sequence, overrun_pending, synchronizers and delay chains to 0.
REQ-031 SHALL abort any in-flight frame on reset; first post-reset frame header = 0 (sequence 0, no overrun).

Verification (NUM_INPUTS=3, MAX_LAG=2, RESOLUTION=4, INTEGRATION_CYCLES=20; frame = 19 words)
REQ-032 Reset released, out_ready=1, no pulses -> after 20 enabled cycles 19 words, header 0x0, all others 0, out_last only on word 19.
REQ-033 One-cycle pulse on input 0 at cycle t, input 1 at t+1 -> pulse counts 1,1,0; pair 0 lag index 1 = 1; all other correlation words 0.
REQ-034 pulse_in[0] and pulse_in[1] held high whole window -> pair 0 lag index 2 = 0xF (saturated, not wrapped).
REQ-035 out_ready low 5 cycles at word 7 -> word 7 data/valid stable for all 5 cycles, no word lost or duplicated.
REQ-036 out_ready low over two window ends -> second window dropped; next sent frame header MSB=1, sequence 2 after frame 0.
REQ-037 reset_n pulsed low mid-frame -> out_valid 0 immediately; next frame header 0x0, counts only post-reset events.

Source files
------------

// File: rtl/correlator_core_if.sv
// Readout stream interface for correlator_core.
// The master side (the core) drives out_data/out_valid/out_last; the slave
// side (the sink) drives out_ready. A word transfers on any rising clock
// edge where out_valid and out_ready are both high.
//   out_data  : RESOLUTION-bit readout word
//   out_valid : out_data holds a valid word
//   out_last  : current word is the final word of the frame
//   out_ready : sink accepts the current word
interface correlator_core_if #(
    parameter int RESOLUTION = 16
);
    logic [RESOLUTION-1:0] out_data;
    logic                  out_valid;
    logic                  out_last;
    logic                  out_ready;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/correlator_core.sv
// Multi-channel pulse correlator.
// Each detector input is synchronised, delayed through a tapped chain and
// used to count rising edges (per input) and coincidences (per input pair
// and per lag -MAX_LAG..+MAX_LAG). At the end of every integration window
// the counters are copied into a snapshot buffer and streamed out as one
// frame: header {overrun, sequence}, NUM_INPUTS pulse counts, then the
// correlation counts pair-major, lag-minor. A window that ends while the
// previous frame is still streaming is dropped and flagged in the next
// header.
// Ports:
//   clk      : sole clock, rising edge
//   reset_n  : asynchronous active-low reset
//   pulse_in : asynchronous detector pulses, one bit per input
//   enable   : high = integrate, low = freeze window timer and counters
//   readout  : readout stream (master side of correlator_core_if)
// MAX_LAG must be at least 1 (the edge detector uses delay tap 1).
module correlator_core #(
    parameter int NUM_INPUTS         = 8,
    parameter int MAX_LAG            = 25,
    parameter int RESOLUTION         = 16,
    parameter int INTEGRATION_CYCLES = 12000000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_INPUTS-1:0] pulse_in,
    input  logic                  enable,
    correlator_core_if.master     readout
);
    localparam int LAGS      = 2 * MAX_LAG + 1;
    localparam int PAIRS     = NUM_INPUTS * (NUM_INPUTS - 1) / 2;
    localparam int NUM_CNT   = NUM_INPUTS + PAIRS * LAGS;
    localparam int NUM_WORDS = 1 + NUM_CNT;
    localparam int TIMER_W   = $clog2(INTEGRATION_CYCLES);
    localparam int IDX_W     = $clog2(NUM_WORDS);
    localparam logic [RESOLUTION-1:0] CNT_MAX = '1;

    typedef enum logic {IDLE, SEND} state_t;

    logic [NUM_INPUTS-1:0] meta_reg;
    // chain_reg[x][n] = synchronised input x delayed n cycles (tap 0 is the
    // second synchroniser flop).
    logic [LAGS-1:0]       chain_reg [NUM_INPUTS];
    logic [NUM_CNT-1:0]    event_vec;
    logic [RESOLUTION-1:0] cnt_reg   [NUM_CNT];
    logic [RESOLUTION-1:0] snap_reg  [NUM_CNT];
    logic [TIMER_W-1:0]    timer_reg;
    logic [RESOLUTION-2:0] seq_reg;
    logic                  overrun_reg;
    state_t                state_reg;
    logic [IDX_W-1:0]      idx_reg;
    logic [RESOLUTION-1:0] data_reg;
    logic                  valid_reg;
    logic                  last_reg;
    logic                  win_end;
    logic                  accept;

    assign win_end = enable && (timer_reg == TIMER_W'(INTEGRATION_CYCLES - 1));
    assign accept  = valid_reg && readout.out_ready;

    assign readout.out_data  = data_reg;
    assign readout.out_valid = valid_reg;
    assign readout.out_last  = last_reg;

    // Synchronisers and delay chains run regardless of enable so that the
    // lag history is continuous when integration resumes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_reg <= '0;
            for (int i = 0; i < NUM_INPUTS; i++) chain_reg[i] <= '0;
        end else begin
            meta_reg <= pulse_in;
            for (int i = 0; i < NUM_INPUTS; i++)
                chain_reg[i] <= {chain_reg[i][LAGS-2:0], meta_reg[i]};
        end
    end

    // Event vector: pulse-count events first, then pair-major/lag-minor
    // coincidence events, matching the frame word order.
    genvar gi, gj, gl;
    generate
        for (gi = 0; gi < NUM_INPUTS; gi++) begin : g_edge
            assign event_vec[gi] = chain_reg[gi][0] & ~chain_reg[gi][1];
        end
        for (gi = 0; gi < NUM_INPUTS; gi++) begin : g_a
            for (gj = gi + 1; gj < NUM_INPUTS; gj++) begin : g_b
                localparam int PAIR = gi * (2 * NUM_INPUTS - gi - 1) / 2 + gj - gi - 1;
                for (gl = 0; gl < LAGS; gl++) begin : g_lag
                    // Input a is observed at the centre tap, so a pulse on b
                    // k cycles after a lines up with tap MAX_LAG-k.
                    assign event_vec[NUM_INPUTS + PAIR * LAGS + gl] =
                        chain_reg[gi][MAX_LAG] & chain_reg[gj][gl];
                end
            end
        end
    endgenerate

    // Saturating counters; the window-end cycle restarts them with that
    // cycle's event so nothing is lost across the boundary.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NUM_CNT; k++) cnt_reg[k] <= '0;
        end else if (enable) begin
            for (int k = 0; k < NUM_CNT; k++) begin
                if (win_end)
                    cnt_reg[k] <= {{(RESOLUTION-1){1'b0}}, event_vec[k]};
                else if (event_vec[k] && cnt_reg[k] != CNT_MAX)
                    cnt_reg[k] <= cnt_reg[k] + RESOLUTION'(1);
            end
        end
    end

    // Snapshot only matters after a window end in IDLE, which always
    // reloads it before it is read, so it needs no reset.
    always_ff @(posedge clk) begin
        if (win_end && state_reg == IDLE)
            for (int k = 0; k < NUM_CNT; k++) snap_reg[k] <= cnt_reg[k];
    end

    // Timer, sequence, overrun flag and the readout FSM with registered
    // outputs. idx_reg is the number of the word currently on out_data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer_reg   <= '0;
            seq_reg     <= '0;
            overrun_reg <= 1'b0;
            state_reg   <= IDLE;
            idx_reg     <= '0;
            data_reg    <= '0;
            valid_reg   <= 1'b0;
            last_reg    <= 1'b0;
        end else begin
            if (enable)
                timer_reg <= win_end ? '0 : timer_reg + TIMER_W'(1);
            if (win_end)
                seq_reg <= seq_reg + (RESOLUTION-1)'(1);
            case (state_reg)
                IDLE: begin
                    if (win_end) begin
                        // The header word is frozen here so it stays stable
                        // under backpressure. The flag it reports is cleared
                        // now, which has the same visible effect as clearing
                        // it on header acceptance while still catching any
                        // window dropped before the header is taken.
                        data_reg    <= {overrun_reg, seq_reg};
                        overrun_reg <= 1'b0;
                        valid_reg   <= 1'b1;
                        last_reg    <= 1'b0;
                        idx_reg     <= '0;
                        state_reg   <= SEND;
                    end
                end
                SEND: begin
                    if (win_end)
                        overrun_reg <= 1'b1;
                    if (accept) begin
                        if (last_reg) begin
                            valid_reg <= 1'b0;
                            last_reg  <= 1'b0;
                            state_reg <= IDLE;
                        end else begin
                            // Word idx+1 lives in snapshot slot idx.
                            data_reg <= snap_reg[idx_reg];
                            last_reg <= (idx_reg == IDX_W'(NUM_WORDS - 2));
                            idx_reg  <= idx_reg + IDX_W'(1);
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule
